// File: rtl/console_text_buffer_pkg.sv
// Shared constants and types for the console text buffer: screen geometry defaults,
// control-code values and the writer state encoding.
package console_text_buffer_pkg;

    localparam int DEFAULT_COLUMNS = 80;
    localparam int DEFAULT_ROWS    = 30;

    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] CHAR_BLANK = 8'h20;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        ROW_CLEAR
    } wr_state_t;

endpackage

// File: rtl/console_text_buffer_if.sv
// Character byte stream into the text buffer: valid/ready handshake carrying a byte
// and the attribute stored alongside it when the byte is printable.
interface console_text_buffer_if;

    logic       char_valid;
    logic [7:0] char_data;
    logic [7:0] char_attr;
    logic       char_ready;

    modport master (output char_valid, output char_data, output char_attr, input char_ready);
    modport slave  (input char_valid, input char_data, input char_attr, output char_ready);

endinterface

// File: rtl/console_text_buffer_text_ram.sv
// Simple dual-port screen memory: one write port, one registered read port.
// A same-cycle read of the address being written returns the previous contents.
module console_text_buffer_text_ram #(
    parameter int DEPTH  = 2400,
    parameter int AW     = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/console_text_buffer.sv
// Text-mode screen memory: byte-stream writer with cursor and rotating-row scroll,
// plus a two-stage read path returning the cell under the HDMI beam.
module console_text_buffer
    import console_text_buffer_pkg::*;
#(
    parameter int         COLUMNS           = DEFAULT_COLUMNS,
    parameter int         ROWS              = DEFAULT_ROWS,
    parameter logic [7:0] DEFAULT_ATTRIBUTE = 8'h0F
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    console_text_buffer_if.slave  chr,
    input  logic [9:0]            cx,
    input  logic [9:0]            cy,
    output logic [7:0]            character,
    output logic [7:0]            attribute
);

    localparam int DEPTH = COLUMNS * ROWS;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(COLUMNS);
    localparam int RW    = $clog2(ROWS);

    // Rotate a logical row by top_row; both operands are < ROWS so one subtract suffices.
    function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] lr, input logic [RW-1:0] top);
        logic [RW:0] sum;
        sum = {1'b0, lr} + {1'b0, top};
        if (sum >= (RW+1)'(ROWS)) begin
            sum = sum - (RW+1)'(ROWS);
        end
        return sum[RW-1:0];
    endfunction

    function automatic logic [AW-1:0] row_base(input logic [RW-1:0] r);
        if (COLUMNS == 80) begin
            return (AW'(r) << 6) + (AW'(r) << 4);
        end else begin
            return AW'(r * COLUMNS);
        end
    endfunction

    wr_state_t     state;
    logic [AW-1:0] cnt;
    logic [AW-1:0] clr_base;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic [RW-1:0] top_row;

    logic              xfer, printable, adv_row;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [15:0]       wdata;

    assign xfer      = chr.char_valid && chr.char_ready;
    assign printable = !(chr.char_data inside {CHAR_LF, CHAR_CR, CHAR_BS, CHAR_FF});
    assign adv_row   = xfer && ((chr.char_data == CHAR_LF) ||
                                (printable && (cur_col == CW'(COLUMNS - 1))));

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = {DEFAULT_ATTRIBUTE, CHAR_BLANK};
        case (state)
            CLEAR: begin
                we    = 1'b1;
                waddr = cnt;
            end
            ROW_CLEAR: begin
                we    = 1'b1;
                waddr = clr_base + cnt;
            end
            IDLE: begin
                we    = xfer && printable;
                waddr = row_base(phys_row(cur_row, top_row)) + AW'(cur_col);
                wdata = {chr.char_attr, chr.char_data};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state          <= CLEAR;
            cnt            <= '0;
            clr_base       <= '0;
            cur_col        <= '0;
            cur_row        <= '0;
            top_row        <= '0;
            chr.char_ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == AW'(DEPTH - 1)) begin
                        state          <= IDLE;
                        cnt            <= '0;
                        cur_col        <= '0;
                        cur_row        <= '0;
                        top_row        <= '0;
                        chr.char_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ROW_CLEAR: begin
                    if (cnt == AW'(COLUMNS - 1)) begin
                        state          <= IDLE;
                        cnt            <= '0;
                        chr.char_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (xfer) begin
                        case (chr.char_data)
                            CHAR_LF, CHAR_CR: cur_col <= '0;
                            CHAR_BS: if (cur_col != '0) cur_col <= cur_col - 1'b1;
                            CHAR_FF: begin
                                state          <= CLEAR;
                                cnt            <= '0;
                                chr.char_ready <= 1'b0;
                            end
                            default: cur_col <= (cur_col == CW'(COLUMNS - 1)) ? '0 : cur_col + 1'b1;
                        endcase
                    end
                    // The physical row leaving the top is the one that becomes the new bottom.
                    if (adv_row) begin
                        if (cur_row != RW'(ROWS - 1)) begin
                            cur_row <= cur_row + 1'b1;
                        end else begin
                            top_row        <= (top_row == RW'(ROWS - 1)) ? '0 : top_row + 1'b1;
                            clr_base       <= row_base(top_row);
                            state          <= ROW_CLEAR;
                            cnt            <= '0;
                            chr.char_ready <= 1'b0;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    logic [6:0]    rd_col;
    logic [5:0]    rd_row;
    logic          rd_oob;
    logic [AW-1:0] rd_addr;
    logic          unused_pixel_bits;

    assign rd_col            = cx[9:3];
    assign rd_row            = cy[9:4];
    assign unused_pixel_bits = ^{cx[2:0], cy[3:0]};
    assign rd_oob  = (32'(rd_col) >= COLUMNS) || (32'(rd_row) >= ROWS);
    assign rd_addr = rd_oob ? '0 : row_base(phys_row(rd_row[RW-1:0], top_row)) + AW'(rd_col[CW-1:0]);

    // Stage p0: registered read address and off-screen flag.
    logic [AW-1:0] raddr_p0;
    logic          oob_p0, oob_p1;
    logic          vld_p0, vld_p1;
    logic [15:0]   rdata_p1;

    always_ff @(posedge clk_pixel) begin
        raddr_p0 <= rd_addr;
        oob_p0   <= rd_oob;
        oob_p1   <= oob_p0;
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= 1'b1;
            vld_p1 <= vld_p0;
        end
    end

    // Stage p1: RAM output register; blanking applied alongside it.
    console_text_buffer_text_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DATA_W(16)
    ) u_ram (
        .clk  (clk_pixel),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(raddr_p0),
        .rdata(rdata_p1)
    );

    assign character = !vld_p1 ? 8'h00 : (oob_p1 ? CHAR_BLANK : rdata_p1[7:0]);
    assign attribute = !vld_p1 ? 8'h00 : (oob_p1 ? 8'h00 : rdata_p1[15:8]);

endmodule

// File: tb/tb_console_text_buffer.sv
// Directed bench for console_text_buffer: clear timing, writes, wrap, scroll, control
// codes and reset abort, with hand-computed expected cell contents.
module tb_console_text_buffer;

    logic       clk_pixel = 1'b0;
    logic       reset;
    logic [9:0] cx, cy;
    logic [7:0] character, attribute;

    console_text_buffer_if chr_if ();

    console_text_buffer dut (
        .clk_pixel(clk_pixel),
        .reset    (reset),
        .chr      (chr_if),
        .cx       (cx),
        .cy       (cy),
        .character(character),
        .attribute(attribute)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_cmp = 0;
    int n_bad = 0;
    int stall_cycles = 0;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic read_pix(input int px, input int py, output logic [7:0] ch, output logic [7:0] at);
        @(negedge clk_pixel);
        cx = 10'(px);
        cy = 10'(py);
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        ch = character;
        at = attribute;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic [7:0] a);
        int t;
        chr_if.char_valid = 1'b1;
        chr_if.char_data  = d;
        chr_if.char_attr  = a;
        t = 0;
        while (chr_if.char_ready !== 1'b1 && t < 5000) begin
            @(negedge clk_pixel);
            t++;
        end
        stall_cycles += t;
        if (t >= 5000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: byte %h never accepted", d);
        end
        @(posedge clk_pixel);
        @(negedge clk_pixel);
        chr_if.char_valid = 1'b0;
    endtask

    task automatic count_ready_low(output int n);
        n = 0;
        while (n < 3000) begin
            @(posedge clk_pixel);
            #1;
            n++;
            if (chr_if.char_ready === 1'b1) break;
        end
    endtask

    task automatic test_reset;
        int n, errs, first;
        logic [7:0] ch, at;
        reset = 1'b1;
        chr_if.char_valid = 1'b0;
        chr_if.char_data  = 8'h00;
        chr_if.char_attr  = 8'h00;
        cx = '0;
        cy = '0;
        repeat (3) @(negedge clk_pixel);
        n_cmp++;
        if (chr_if.char_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", chr_if.char_ready); end
        n_cmp++;
        if (character !== 8'h00) begin n_bad++; $display("FAIL reset_char: got %h want 00", character); end
        n_cmp++;
        if (attribute !== 8'h00) begin n_bad++; $display("FAIL reset_attr: got %h want 00", attribute); end
        reset = 1'b0;
        count_ready_low(n);
        n_cmp++;
        if (n != 2400) begin n_bad++; $display("FAIL clear_len: ready rose after %0d edges, want 2400", n); end
        errs = 0;
        first = -1;
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 80; c++) begin
                read_pix(c * 8 + (c % 8), r * 16 + (r % 16), ch, at);
                if (ch !== 8'h20 || at !== 8'h0F) begin
                    errs++;
                    if (first < 0) first = r * 80 + c;
                end
            end
        end
        n_cmp++;
        if (errs != 0) begin n_bad++; $display("FAIL blank_sweep: %0d bad cells (first %0d), want 0", errs, first); end
        read_pix(640, 0, ch, at);
        n_cmp++;
        if (ch !== 8'h20 || at !== 8'h00) begin n_bad++; $display("FAIL oob_col: got %h/%h want 20/00", ch, at); end
        read_pix(0, 480, ch, at);
        n_cmp++;
        if (ch !== 8'h20 || at !== 8'h00) begin n_bad++; $display("FAIL oob_row: got %h/%h want 20/00", ch, at); end
        read_pix(1023, 1023, ch, at);
        n_cmp++;
        if (ch !== 8'h20 || at !== 8'h00) begin n_bad++; $display("FAIL oob_max: got %h/%h want 20/00", ch, at); end
        read_pix(639, 479, ch, at);
        n_cmp++;
        if (ch !== 8'h20 || at !== 8'h0F) begin n_bad++; $display("FAIL last_cell: got %h/%h want 20/0F", ch, at); end
    endtask

    task automatic test_ab;
        int errs;
        logic [7:0] ch, at;
        send_byte(8'h41, 8'h1E);
        send_byte(8'h42, 8'h1E);
        read_pix(0, 0, ch, at);
        n_cmp++;
        if (ch !== 8'h41 || at !== 8'h1E) begin n_bad++; $display("FAIL cell_A: got %h/%h want 41/1E", ch, at); end
        cx = 10'd8;
        cy = 10'd0;
        @(negedge clk_pixel);
        n_cmp++;
        if (character !== 8'h41) begin n_bad++; $display("FAIL lat_1cyc: got %h want 41 (old cell)", character); end
        @(negedge clk_pixel);
        n_cmp++;
        if (character !== 8'h42 || attribute !== 8'h1E) begin
            n_bad++; $display("FAIL lat_2cyc: got %h/%h want 42/1E", character, attribute);
        end
        errs = 0;
        for (int y = 0; y < 16; y++) begin
            for (int x = 8; x < 16; x++) begin
                read_pix(x, y, ch, at);
                if (ch !== 8'h42 || at !== 8'h1E) errs++;
            end
        end
        n_cmp++;
        if (errs != 0) begin n_bad++; $display("FAIL cell_B_pixels: %0d bad pixels, want 0", errs); end
        read_pix(16, 0, ch, at);
        n_cmp++;
        if (ch !== 8'h20 || at !== 8'h0F) begin n_bad++; $display("FAIL after_B: got %h/%h want 20/0F", ch, at); end
    endtask

    task automatic test_wrap;
        logic [7:0] ch, at;
        send_byte(8'h0D, 8'h00);
        stall_cycles = 0;
        for (int i = 0; i < 80; i++) send_byte(8'h78, 8'h07);
        send_byte(8'h79, 8'h07);
        n_cmp++;
        if (stall_cycles != 0) begin n_bad++; $display("FAIL wrap_stall: %0d stall cycles, want 0", stall_cycles); end
        read_pix(79 * 8, 0, ch, at);
        n_cmp++;
        if (ch !== 8'h78 || at !== 8'h07) begin n_bad++; $display("FAIL wrap_last_x: got %h/%h want 78/07", ch, at); end
        read_pix(0, 16, ch, at);
        n_cmp++;
        if (ch !== 8'h79 || at !== 8'h07) begin n_bad++; $display("FAIL wrap_y: got %h/%h want 79/07", ch, at); end
        read_pix(8, 16, ch, at);
        n_cmp++;
        if (ch !== 8'h20 || at !== 8'h0F) begin n_bad++; $display("FAIL wrap_after_y: got %h/%h want 20/0F", ch, at); end
    endtask

    task automatic test_bs_cr;
        logic [7:0] ch, at;
        send_byte(8'h0A, 8'h00);
        send_byte(8'h08, 8'h00);
        send_byte(8'h71, 8'h0F);
        read_pix(0, 32, ch, at);
        n_cmp++;
        if (ch !== 8'h71) begin n_bad++; $display("FAIL bs_col0_q: got %h want 71", ch); end
        read_pix(8, 32, ch, at);
        n_cmp++;
        if (ch !== 8'h20) begin n_bad++; $display("FAIL bs_after_q: got %h want 20", ch); end
        send_byte(8'h0A, 8'h00);
        send_byte(8'h61, 8'h0F);
        send_byte(8'h62, 8'h0F);
        send_byte(8'h63, 8'h0F);
        send_byte(8'h0D, 8'h00);
        send_byte(8'h58, 8'h0F);
        read_pix(0, 48, ch, at);
        n_cmp++;
        if (ch !== 8'h58) begin n_bad++; $display("FAIL cr_X: got %h want 58", ch); end
        read_pix(8, 48, ch, at);
        n_cmp++;
        if (ch !== 8'h62) begin n_bad++; $display("FAIL cr_b: got %h want 62", ch); end
        read_pix(16, 48, ch, at);
        n_cmp++;
        if (ch !== 8'h63) begin n_bad++; $display("FAIL cr_c: got %h want 63", ch); end
        send_byte(8'h08, 8'h00);
        send_byte(8'h57, 8'h0F);
        read_pix(0, 48, ch, at);
        n_cmp++;
        if (ch !== 8'h57) begin n_bad++; $display("FAIL bs_dec: got %h want 57", ch); end
    endtask

    task automatic test_ff;
        int n, errs;
        logic [7:0] ch, at;
        send_byte(8'h0C, 8'h00);
        count_ready_low(n);
        n_cmp++;
        if (n != 2400) begin n_bad++; $display("FAIL ff_len: ready low %0d edges, want 2400", n); end
        errs = 0;
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 80; c++) begin
                read_pix(c * 8, r * 16, ch, at);
                if (ch !== 8'h20 || at !== 8'h0F) errs++;
            end
        end
        n_cmp++;
        if (errs != 0) begin n_bad++; $display("FAIL ff_blank: %0d bad cells, want 0", errs); end
        send_byte(8'h4B, 8'h0F);
        read_pix(0, 0, ch, at);
        n_cmp++;
        if (ch !== 8'h4B) begin n_bad++; $display("FAIL ff_cursor: got %h want 4B at (0,0)", ch); end
        read_pix(8, 0, ch, at);
        n_cmp++;
        if (ch !== 8'h20) begin n_bad++; $display("FAIL ff_after_K: got %h want 20", ch); end
    endtask

    task automatic test_scroll;
        int n, errs;
        logic [7:0] ch, at;
        send_byte(8'h0D, 8'h00);
        stall_cycles = 0;
        for (int i = 0; i < 29; i++) send_byte(8'h0A, 8'h00);
        send_byte(8'h7A, 8'h2F);
        n_cmp++;
        if (stall_cycles != 0) begin n_bad++; $display("FAIL lf_stall: %0d stall cycles, want 0", stall_cycles); end
        read_pix(0, 29 * 16, ch, at);
        n_cmp++;
        if (ch !== 8'h7A || at !== 8'h2F) begin n_bad++; $display("FAIL z_row29: got %h/%h want 7A/2F", ch, at); end
        send_byte(8'h0A, 8'h00);
        count_ready_low(n);
        n_cmp++;
        if (n != 80) begin n_bad++; $display("FAIL row_clear_len: ready low %0d edges, want 80", n); end
        read_pix(0, 28 * 16, ch, at);
        n_cmp++;
        if (ch !== 8'h7A || at !== 8'h2F) begin n_bad++; $display("FAIL z_row28: got %h/%h want 7A/2F", ch, at); end
        errs = 0;
        for (int c = 0; c < 80; c++) begin
            read_pix(c * 8, 29 * 16, ch, at);
            if (ch !== 8'h20 || at !== 8'h0F) errs++;
        end
        n_cmp++;
        if (errs != 0) begin n_bad++; $display("FAIL row29_blank: %0d bad cells, want 0", errs); end
        send_byte(8'h77, 8'h0F);
        read_pix(0, 29 * 16, ch, at);
        n_cmp++;
        if (ch !== 8'h77) begin n_bad++; $display("FAIL scrolled_write: got %h want 77", ch); end
    endtask

    task automatic test_reset_mid_row_clear;
        int n;
        logic [7:0] ch, at;
        send_byte(8'h0A, 8'h00);
        repeat (40) @(negedge clk_pixel);
        n_cmp++;
        if (chr_if.char_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rc_ready: got %b want 0", chr_if.char_ready); end
        reset = 1'b1;
        @(negedge clk_pixel);
        n_cmp++;
        if (character !== 8'h00) begin n_bad++; $display("FAIL mid_rc_reset_char: got %h want 00", character); end
        reset = 1'b0;
        count_ready_low(n);
        n_cmp++;
        if (n != 2400) begin n_bad++; $display("FAIL restart_clear_len: %0d edges, want 2400", n); end
        read_pix(0, 28 * 16, ch, at);
        n_cmp++;
        if (ch !== 8'h20 || at !== 8'h0F) begin n_bad++; $display("FAIL restart_blank: got %h/%h want 20/0F", ch, at); end
        send_byte(8'h52, 8'h0F);
        read_pix(0, 0, ch, at);
        n_cmp++;
        if (ch !== 8'h52) begin n_bad++; $display("FAIL restart_cursor: got %h want 52", ch); end
    endtask

    initial begin
        test_reset();
        test_ab();
        test_wrap();
        test_bs_cr();
        test_ff();
        test_scroll();
        test_reset_mid_row_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
